// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding controller for a 5-stage pipeline with mul/div occupancy and watchdog.
// Optional macro PIPE_HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_MAX_CYC = 40,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              ex_wen,
  input  logic              mem_wen,
  input  logic              ex_is_load,
  input  logic              ex_jb,
  input  logic              ex_md_start,
  input  logic              md_done,
  output logic              pc_stall,
  output logic              d_stall,
  output logic              d_flush,
  output logic              e_flush,
  output logic              e_hold,
  output logic              m_flush,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic              md_timeout
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);
  localparam int WD_W = $clog2(MD_MAX_CYC + 1);
  typedef enum logic {RUN, MD_WAIT} state_t;
  state_t           r_state;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [1:0]       r_fwd1, r_fwd2;
  logic             r_md_timeout;
  logic             w_timeout, w_md_hold, w_jb, w_lu, w_hit;
  logic [1:0]       w_fwd1, w_fwd2;
  assign w_timeout = r_state == MD_WAIT && r_wd_cnt == WD_W'(MD_MAX_CYC - 1);
  assign w_md_hold = !rst && ((r_state == RUN && ex_md_start && !md_done) ||
                              (r_state == MD_WAIT && !md_done && !w_timeout));
  assign w_hit = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  assign w_jb = !rst && !w_md_hold && ex_jb;
  assign w_lu = !rst && !w_md_hold && !ex_jb && ex_is_load && ex_wen && ex_rd != '0 && w_hit;
  assign pc_stall = w_md_hold || w_lu;
  assign d_stall  = w_md_hold || w_lu;
  assign d_flush  = w_jb;
  assign e_flush  = w_jb || w_lu;
  assign e_hold   = w_md_hold;
  assign m_flush  = w_md_hold;
  assign w_fwd1 = (!id_use_rs1 || id_rs1 == '0) ? 2'b00 :
                  (ex_wen && ex_rd == id_rs1)   ? 2'b01 :
                  (mem_wen && mem_rd == id_rs1) ? 2'b10 : 2'b00;
  assign w_fwd2 = (!id_use_rs2 || id_rs2 == '0) ? 2'b00 :
                  (ex_wen && ex_rd == id_rs2)   ? 2'b01 :
                  (mem_wen && mem_rd == id_rs2) ? 2'b10 : 2'b00;
  assign fwd1_sel   = r_fwd1;
  assign fwd2_sel   = r_fwd2;
  assign md_timeout = r_md_timeout;
  // mul/div occupancy FSM, watchdog, sticky timeout flag and ID/EX forwarding selects
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_wd_cnt     <= '0;
      r_fwd1       <= 2'b00;
      r_fwd2       <= 2'b00;
      r_md_timeout <= 1'b0;
    end else begin
      r_state      <= r_state == RUN ? ((ex_md_start && !md_done) ? MD_WAIT : RUN)
                                     : ((md_done || w_timeout) ? RUN : MD_WAIT);
      r_wd_cnt     <= r_state == MD_WAIT ? r_wd_cnt + 1'b1 : '0;
      r_md_timeout <= r_md_timeout || w_timeout;
      r_fwd1       <= e_flush ? 2'b00 : e_hold ? r_fwd1 : w_fwd1;
      r_fwd2       <= e_flush ? 2'b00 : e_hold ? r_fwd2 : w_fwd2;
    end
  end
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  // saturating counts of stalled and flushed cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= (pc_stall && ~&r_stall_cnt) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      r_flush_cnt <= (d_flush && ~&r_flush_cnt) ? r_flush_cnt + 1'b1 : r_flush_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a rule-level reference model for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  localparam int MD_MAX_CYC = 40;
  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, exrd, memrd;
    logic       u1, u2, exw, memw, ld, jb, st, done;
  } in_t;
  typedef struct {
    logic       pc, ds, df, ef, eh, mf, to;
    logic [1:0] f1, f2;
    bit         chk_reg;
  } exp_t;
  logic clk = 0;
  in_t  cur;
  logic pc_stall, d_stall, d_flush, e_flush, e_hold, m_flush, md_timeout;
  logic [1:0] fwd1_sel, fwd2_sel;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  int m_scnt = 0, m_fcnt = 0;
`endif
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  bit   m_busy = 0, m_to = 0, m_known = 0;
  int   m_held = 0;
  logic [1:0] m_f1 = 0, m_f2 = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_AW(5), .MD_MAX_CYC(MD_MAX_CYC), .CNT_W(32)) dut (
    .clk(clk), .rst(cur.rst),
    .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_use_rs1(cur.u1), .id_use_rs2(cur.u2),
    .ex_rd(cur.exrd), .mem_rd(cur.memrd), .ex_wen(cur.exw), .mem_wen(cur.memw),
    .ex_is_load(cur.ld), .ex_jb(cur.jb), .ex_md_start(cur.st), .md_done(cur.done),
    .pc_stall(pc_stall), .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
    .e_hold(e_hold), .m_flush(m_flush), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .md_timeout(md_timeout)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    n_checks++;
    if (a !== b) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", n, a, b, $time);
    end
  endtask
  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction
  // Source a register operand: newest in-flight producer wins, x0 and unused operands read the regfile.
  function automatic logic [1:0] fsel(input logic u, input logic [4:0] rs, input in_t v);
    if (!u || rs == 0) return 2'd0;
    if (v.exw && v.exrd == rs) return 2'd1;
    if (v.memw && v.memrd == rs) return 2'd2;
    return 2'd0;
  endfunction
  // Drive one cycle of inputs and push what the pipeline rules say the outputs must be.
  task automatic step(input in_t v);
    exp_t e;
    bit hold, to, lu;
    @(posedge clk);
    #1;
    cur = v;
    e = '{default: '0};
    e.chk_reg = m_known;
    e.f1 = m_f1;
    e.f2 = m_f2;
    e.to = m_to;
    if (v.rst) begin
      m_busy = 0; m_held = 0; m_to = 0; m_f1 = 0; m_f2 = 0; m_known = 1;
`ifdef PIPE_HAZARD_PERF_CNT_EN
      m_scnt = 0; m_fcnt = 0;
`endif
    end else begin
      to = 0;
      if (!m_busy) hold = v.st && !v.done;
      else begin
        to = !v.done && m_held == MD_MAX_CYC;
        hold = !v.done && !to;
      end
      m_busy = hold;
      m_held = hold ? m_held + 1 : 0;
      lu = !hold && !v.jb && v.ld && v.exw && v.exrd != 0 &&
           ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd));
      e.pc = hold || lu;
      e.ds = hold || lu;
      e.df = !hold && v.jb;
      e.ef = !hold && (v.jb || lu);
      e.eh = hold;
      e.mf = hold;
      if (to) m_to = 1;
      if (e.ef) begin m_f1 = 0; m_f2 = 0; end
      else if (!e.eh) begin m_f1 = fsel(v.u1, v.rs1, v); m_f2 = fsel(v.u2, v.rs2, v); end
`ifdef PIPE_HAZARD_PERF_CNT_EN
      m_scnt += int'(e.pc);
      m_fcnt += int'(e.df);
`endif
    end
    sb.push_back(e);
  endtask
  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc_stall", pc_stall, e.pc);
      chk("d_stall", d_stall, e.ds);
      chk("d_flush", d_flush, e.df);
      chk("e_flush", e_flush, e.ef);
      chk("e_hold", e_hold, e.eh);
      chk("m_flush", m_flush, e.mf);
      if (e.chk_reg) begin
        chk("fwd1_sel", fwd1_sel, e.f1);
        chk("fwd2_sel", fwd2_sel, e.f2);
        chk("md_timeout", md_timeout, e.to);
      end
    end
  end
  initial begin
    in_t v;
    cur = idle();
    cur.rst = 1;
    v = idle(); v.rst = 1;
    step(v); step(v);
    step(idle());
    v = idle(); v.st = 1;
    repeat (5) step(v);
    v.done = 1; step(v);
    v = idle(); v.jb = 1; step(v);
    step(idle());
`ifdef PIPE_HAZARD_PERF_CNT_EN
    @(negedge clk);
    chk("stall_cnt", stall_cnt, 32'd5);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif
    v = idle(); v.ld = 1; v.exw = 1; v.exrd = 5; v.u1 = 1; v.rs1 = 5; step(v);
    v = idle(); v.memw = 1; v.memrd = 5; v.u1 = 1; v.rs1 = 5; step(v);
    step(idle());
    v = idle(); v.exw = 1; v.exrd = 7; v.u2 = 1; v.rs2 = 7; step(v);
    v.exrd = 0; v.rs2 = 0; step(v);
    step(idle());
    v = idle(); v.ld = 1; v.exw = 1; v.exrd = 3; v.u2 = 1; v.rs2 = 3; v.jb = 1; step(v);
    step(idle());
    v = idle(); v.st = 1;
    repeat (MD_MAX_CYC + 1) step(v);
    repeat (3) step(idle());
    v = idle(); v.st = 1;
    repeat (3) step(v);
    v.rst = 1; step(v);
    v = idle(); v.done = 1; step(v);
    step(idle());
    repeat (3000) begin
      v.rst   = ($urandom % 256) == 0;
      v.rs1   = 5'($urandom % 4);
      v.rs2   = 5'($urandom % 4);
      v.exrd  = 5'($urandom % 4);
      v.memrd = 5'($urandom % 4);
      v.u1    = 1'($urandom);
      v.u2    = 1'($urandom);
      v.exw   = 1'($urandom);
      v.memw  = 1'($urandom);
      v.ld    = ($urandom % 3) == 0;
      v.jb    = ($urandom % 8) == 0;
      v.st    = m_busy ? 1'b1 : ($urandom % 10) == 0;
      v.done  = ($urandom % 6) == 0;
      step(v);
    end
    step(idle());
    @(negedge clk);
    @(negedge clk);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall_cnt_end", stall_cnt, 32'(m_scnt));
    chk("flush_cnt_end", flush_cnt, 32'(m_fcnt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives hold and bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences multi-cycle multiply/divide occupancy of EX, with a watchdog.
- Produces registered EX-operand forwarding selects that travel alongside ID/EX.

Parameters:
- REG_AW, 5, register index width.
- MD_MAX_CYC, 40, watchdog limit in cycles for one multi-cycle operation.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd, mem_rd  in  REG_AW  destination index in EX/MEM.
- ex_wen, mem_wen  in  1  EX/MEM instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_jb  in  1  EX resolved taken branch/jump (redirect).
- ex_md_start  in  1  EX holds a multi-cycle mul/div op.
- md_done  in  1  mul/div unit result valid this cycle.
- pc_stall  out  1  hold PC.
- d_stall  out  1  hold IF/ID.
- d_flush  out  1  zero IF/ID.
- e_flush  out  1  bubble (zero) ID/EX.
- e_hold  out  1  hold ID/EX.
- m_flush  out  1  bubble EX/MEM.
- fwd1_sel, fwd2_sel  out  2  registered EX operand source: 00 regfile, 01 MEM result, 10 WB result.
- md_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=1 at edge): state=RUN; wd_cnt=0; fwd*_sel=00; md_timeout=0. All control outputs are 0 during and after reset until inputs dictate otherwise.
- FSM states:
  - RUN -> MD_WAIT when ex_md_start=1 and md_done=0.
  - MD_WAIT -> RUN on md_done=1 or on timeout.
- md_hold is combinational: (RUN & ex_md_start & !md_done) | (MD_WAIT & !md_done & !timeout).
  - While md_hold: pc_stall=d_stall=e_hold=m_flush=1; d_flush=e_flush=0.
  - Cycle with md_done=1: all four deasserted and the op advances.
- Watchdog:
  - wd_cnt clears on entering MD_WAIT and increments each MD_WAIT cycle.
  - timeout = (wd_cnt == MD_MAX_CYC-1) in MD_WAIT. On timeout: release as if md_done, set md_timeout=1; it stays set until rst.
- Branch: when !md_hold and ex_jb=1: d_flush=1, e_flush=1, pc_stall=0, d_stall=0. Load-use is suppressed that cycle.
- Load-use: when !md_hold, !ex_jb, ex_is_load, ex_wen, ex_rd!=0 and ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): pc_stall=d_stall=e_flush=1 for exactly one cycle. There is no state; the condition clears once the load advances.
- Priority: md_hold > ex_jb > load-use.
- Forwarding, per operand n, computed in ID, gated by id_use_rsn and index!=0:
  - ex_wen & ex_rd match -> 01.
  - else mem_wen & mem_rd match -> 10.
  - else 00.
  - Register update: e_flush -> load 00; else e_hold -> keep; else load computed value.
  - Register file is write-through for WB, so WB-stage producers need no select.
- Reset mid-MD_WAIT returns to RUN on the same edge; md_done arriving later is ignored in RUN unless ex_md_start=1.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cnt and flush_cnt (CNT_W each).
  - stall_cnt increments every cycle pc_stall=1.
  - flush_cnt increments every cycle d_flush=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; there is no other behavioural difference.

Test Plan:
- Load x5 in EX (ex_is_load=1, ex_wen=1, ex_rd=5), ID reads id_rs1=5 -> pc_stall=d_stall=e_flush=1 for 1 cycle; next cycle fwd1_sel=10.
- ex_wen=1, ex_rd=7, ID id_rs2=7, non-load -> no stall; after edge fwd2_sel=01. Same with ex_rd=0 -> fwd2_sel=00.
- ex_jb=1 coincident with a load-use hazard -> d_flush=e_flush=1, pc_stall=0 for 1 cycle; fwd sels 00 next cycle.
- ex_md_start=1, md_done on 6th cycle -> pc_stall/d_stall/e_hold/m_flush high 5 cycles, low on the md_done cycle; state back to RUN.
- ex_md_start=1, md_done never (MD_MAX_CYC=40) -> release after timeout; md_timeout=1 and sticky; rst clears it.
- With PIPE_HAZARD_PERF_CNT_EN, the 5-cycle md stall plus 1 branch -> stall_cnt=5, flush_cnt=1.
